// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq : sequences unsigned 8x8 multiply / 8/8 divide on a shared ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
  parameter logic [3:0] ADD_OP = 4'b0000,
  parameter logic [3:0] SUB_OP = 4'b0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] alu_d0,
  output logic [7:0] alu_d1,
  output logic [3:0] alu_op,
  output logic       alu_c_in,
  input  logic [7:0] alu_y,
  input  logic       alu_c_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [7:0]  b_reg_q, b_reg_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic [7:0]  res_hi_q, res_hi_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic [7:0]  shifted_rem;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    b_reg_d     = b_reg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    alu_d0      = 8'h00;
    alu_d1      = 8'h00;
    alu_op      = ADD_OP;
    alu_c_in    = 1'b0;
    shifted_rem = {hi_q[6:0], lo_q[7]};

    case (state_q)
      S_RUN: begin
        cnt_d  = cnt_q + 3'd1;
        alu_d1 = b_reg_q;
        if (!op_q) begin
          alu_op = ADD_OP;
          alu_d0 = hi_q;
          if (lo_q[0]) {hi_d, lo_d} = {alu_c_out, alu_y, lo_q[7:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[7:1]};
        end else begin
          alu_op = SUB_OP;
          alu_d0 = shifted_rem;
          // hi[7] set means the shifted remainder exceeds 255, so it beats any divisor
          if (hi_q[7] || !alu_c_out) begin
            hi_d = alu_y;
            lo_d = {lo_q[6:0], 1'b1};
          end else begin
            hi_d = shifted_rem;
            lo_d = {lo_q[6:0], 1'b0};
          end
        end
        if (cnt_q == 3'd7) begin
          state_d  = S_DONE;
          res_hi_d = hi_d;
          res_lo_d = lo_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      op_d    = op;
      b_reg_d = b;
      lo_d    = a;
      hi_d    = 8'h00;
      cnt_d   = 3'd0;
      dbz_d   = 1'b0;
      state_d = S_RUN;
      if (op && b == 8'h00) begin
        state_d  = S_DONE;
        res_hi_d = a;
        res_lo_d = 8'hFF;
        dbz_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      b_reg_q  <= 8'h00;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      cnt_q    <= 3'd0;
      dbz_q    <= 1'b0;
      res_hi_q <= 8'h00;
      res_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_reg_q  <= b_reg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      dbz_q    <= dbz_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: arithmetic reference model, per-cycle comparison, directed and random ops.
`default_nettype none

module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] alu_d0, alu_d1, alu_y;
  logic [3:0] alu_op;
  logic       alu_c_in, alu_c_out;
  logic       busy, done, div_by_zero;
  logic [7:0] result_hi, result_lo;
  logic [8:0] alu_sum;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_y(alu_y), .alu_c_out(alu_c_out), .busy(busy), .done(done),
    .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Shared 8-bit ALU: add gives carry-out, subtract gives borrow
  always_comb begin
    alu_sum = 9'd0;
    if (alu_op == 4'b0001) alu_sum = {1'b0, alu_d0} - {1'b0, alu_d1};
    else                   alu_sum = {1'b0, alu_d0} + {1'b0, alu_d1};
  end
  assign alu_y     = alu_sum[7:0];
  assign alu_c_out = alu_sum[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result computed with plain arithmetic, delivered after 8 busy cycles
  bit       m_busy = 0, m_done = 0, m_dbz = 0;
  bit [7:0] m_rh = 0, m_rl = 0;
  bit [15:0] m_pend = 0;
  int       m_rem = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_rh = 0; m_rl = 0; m_rem = 0;
    end else if (m_busy) begin
      m_done = 0;
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
        {m_rh, m_rl} = m_pend;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_dbz = 0;
        if (op && b == 8'h00) begin
          m_rh = a; m_rl = 8'hFF; m_dbz = 1; m_done = 1;
        end else begin
          m_busy = 1;
          m_rem  = 8;
          if (op) m_pend = {a % b, a / b};
          else    m_pend = 16'(a) * 16'(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("result_hi", result_hi, m_rh);
      chk("result_lo", result_lo, m_rl);
      chk("div_by_zero", div_by_zero, m_dbz);
      chk("alu_c_in", alu_c_in, 1'b0);
      if (!m_busy) begin
        chk("idle_alu_d0", alu_d0, 8'h00);
        chk("idle_alu_d1", alu_d1, 8'h00);
        chk("idle_alu_op", alu_op, 4'h0);
      end
    end
  end

  // Issue one op at a negedge; return at the negedge where done is seen (bounded)
  task automatic run_op(input string nm, input logic o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eh, input logic [7:0] el, input logic ez, input int elat);
    int lat, nbusy;
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (!done && lat < 20) begin
      nbusy += int'(busy);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, nbusy, elat - 1);
    chk({nm, "_hi"}, result_hi, eh);
    chk({nm, "_lo"}, result_lo, el);
    chk({nm, "_dbz"}, div_by_zero, ez);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_res", {result_hi, result_lo}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_ff_ff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 9);
    run_op("mul_13_11", 1'b0, 8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, 9);
    run_op("mul_0_7f",  1'b0, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b0, 9);
    run_op("div_200_7", 1'b1, 8'd200, 8'd7, 8'h04, 8'h1C, 1'b0, 9);
    run_op("div_ff_80", 1'b1, 8'hFF, 8'h80, 8'h7F, 8'h01, 1'b0, 9);
    run_op("div_ff_ff", 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 9);
    run_op("div_by_0",  1'b1, 8'h5A, 8'h00, 8'h5A, 8'hFF, 1'b1, 1);
    run_op("mul_after_dbz", 1'b0, 8'd3, 8'd5, 8'h00, 8'h0F, 1'b0, 9);
    repeat (2) @(negedge clk);

    // Starts during RUN must not disturb the in-flight multiply
    start = 1'b1; op = 1'b0; a = 8'd13; b = 8'd11;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'hFF; b = 8'h03;
    repeat (3) @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      chk("ignored_start_wait", n, 5);
    end
    chk("ignored_start_res", {result_hi, result_lo}, 16'h008F);
    @(negedge clk);

    // Reset in the middle of RUN
    start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_res", {result_hi, result_lo}, 16'h0000);
    chk("rst_mid_alu", {alu_d0, alu_d1, alu_op}, 20'h0);
    reset = 1'b0;
    run_op("post_rst_mul", 1'b0, 8'd20, 8'd20, 8'h01, 8'h90, 1'b0, 9);

    // Random ops with random extra starts, including back-to-back and divide by zero
    repeat (150) begin
      start = 1'b1; op = 1'($urandom); a = 8'($urandom);
      b = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      @(negedge clk);
      repeat ($urandom_range(0, 12)) begin
        start = ($urandom % 5 == 0); op = 1'($urandom); a = 8'($urandom);
        b = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
